uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, is the first byte of every frame.
REQ-002 Parameter FIFO_DEPTH, default 4, is the number of input-word FIFO entries; legal values are powers of two from 2 to 16.
REQ-003 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  is the asynchronous, active-high reset.
REQ-005 Port in_data  input  16  is the payload word from the producer.
REQ-006 Port in_valid  input  1  means in_data is valid.
REQ-007 Port in_ready  output  1  means the block can accept a word.
REQ-008 Port out_data  output  8  is the frame byte to the UART controller's data input.
REQ-009 Port out_valid  output  1  means out_data is valid; it connects to the controller's valid input.
REQ-010 Port out_ready  input  1  is the controller's ready; the controller may drive it combinationally.
REQ-011 Port frame_count  output  16  is the number of completed frames, wrapping.
REQ-012 Port busy  output  1  is high when the FSM is outside IDLE or the FIFO is non-empty.

Function
REQ-013 An input transfer occurs on an edge with in_valid && in_ready; an output transfer occurs on an edge with out_valid && out_ready.
REQ-014 in_ready SHALL equal (FIFO count < FIFO_DEPTH), be derived from registers only, and ignore same-cycle pops.
REQ-015 out_valid and out_data SHALL be derived from registers only, never from out_ready.
REQ-016 Once asserted, out_valid and out_data SHALL hold steady until the output transfer occurs.
REQ-017 A push and a pop in the same cycle SHALL leave the FIFO count unchanged, with FIFO order preserved.
REQ-018 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 The FSM SHALL have the states IDLE, SYNC, HI, LO and CSUM.
REQ-020 In IDLE with the FIFO non-empty, the FSM SHALL pop the head into a shadow register and enter SYNC on the next edge.
REQ-021 The SYNC state SHALL drive out_data=SYNC_BYTE.
REQ-022 The HI state SHALL drive out_data=shadow[15:8].
REQ-023 The LO state SHALL drive out_data=shadow[7:0].
REQ-024 The CSUM state SHALL drive out_data=shadow[15:8]^shadow[7:0].
REQ-025 Each byte state SHALL advance to the next state only on an output transfer.
REQ-026 On frame completion with the FIFO non-empty, the FSM SHALL pop the next word and enter SYNC with no IDLE cycle; otherwise it SHALL enter IDLE.
REQ-027 Latency: a word accepted into an empty, idle block at edge N SHALL have out_valid=1 with SYNC_BYTE from edge N+2.
REQ-028 Back-to-back frames with out_ready held high SHALL sustain one byte per cycle.
REQ-029 frame_count SHALL increment by 1 on the final-byte transfer of each frame and wrap from 16'hFFFF to 16'h0000.
REQ-030 out_valid SHALL be 0 in IDLE.

Reset
REQ-031 Asserting rst at any time, including mid-frame, SHALL immediately set the FSM to IDLE, the FIFO to empty and frame_count to 0.
REQ-032 While rst is asserted, out_valid SHALL be 0, out_data 8'h00, in_ready 0 and busy 0.
REQ-033 A partially sent frame SHALL be discarded at reset and not resumed.
REQ-034 in_ready SHALL rise on the first clock edge after rst deasserts.

Configuration
REQ-035 The macro UART_TX_FRAMER_CHECKSUM_EN, when defined, SHALL enable the CSUM state, giving 4-byte frames.
REQ-036 When UART_TX_FRAMER_CHECKSUM_EN is undefined, CSUM SHALL be absent, LO SHALL be the final byte (3-byte frames), and frame_count SHALL increment on the LO transfer.

Verification
REQ-037 Checksum on, out_ready=1, push 16'h1234 -> bytes A5,12,34,26 on consecutive cycles; frame_count=1.
REQ-038 Checksum off, push 16'h1234 -> bytes A5,12,34; frame_count increments on the 34 transfer.
REQ-039 Push 16'hBEEF, hold out_ready=0 for 5 cycles while in HI -> out_data stays 8'hBE with out_valid=1, then EF follows when out_ready=1.
REQ-040 out_ready=0, push continuously -> exactly 5 words accepted (1 shadow + 4 FIFO), in_ready=0 after; release -> 5 frames in push order.
REQ-041 Preload frame_count to 16'hFFFF via 65535 frames, send one more -> frame_count=16'h0000.
REQ-042 Assert rst during LO of a frame -> out_valid=0 at once, frame_count=0; after release, a new push of 16'h00FF yields A5,00,FF(,FF).

Source files
------------

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: packs 16-bit producer words into byte frames for a UART
// controller. Each frame is SYNC_BYTE, high byte, low byte and, when the
// UART_TX_FRAMER_CHECKSUM_EN macro is defined, an XOR checksum byte.
// Words queue in a small FIFO. The FSM copies the head word into a shadow
// register and then streams its bytes over a valid/ready handshake.
// All outputs come straight from registers, so out_ready never reaches them
// combinationally.
module uart_tx_framer #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [2:0] {IDLE, SYNC, HI, LO, CSUM} state_t;

`ifdef UART_TX_FRAMER_CHECKSUM_EN
  localparam state_t LAST_STATE = CSUM;
`else
  localparam state_t LAST_STATE = LO;
`endif

  logic [15:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0] r_count;
  logic           r_rstDone;

  state_t         r_state;
  logic [15:0]    r_shadow;
  logic           r_shadowFull;
  logic           r_outValid;
  logic [7:0]     r_outData;
  logic [15:0]    r_frameCount;

  logic w_push;
  logic w_pop;
  logic w_fifoEmpty;
  logic w_xfer;
  logic w_lastXfer;
  logic w_idleLoad;
  logic w_chainLoad;

  assign w_fifoEmpty = (r_count == '0);
  assign w_xfer      = r_outValid && out_ready;
  assign w_lastXfer  = w_xfer && (r_state == LAST_STATE);
  assign w_idleLoad  = (r_state == IDLE) && !r_shadowFull && !w_fifoEmpty;
  assign w_chainLoad = w_lastXfer && !w_fifoEmpty;
  assign w_pop       = w_idleLoad || w_chainLoad;
  assign w_push      = in_valid && in_ready;

  assign in_ready    = r_rstDone && (r_count < DEPTH_CNT);
  assign out_valid   = r_outValid;
  assign out_data    = r_outData;
  assign frame_count = r_frameCount;
  assign busy        = (r_state != IDLE) || r_shadowFull || !w_fifoEmpty;

  // Hold in_ready low until the first clock edge after reset is released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rstDone <= 1'b0;
    else     r_rstDone <= 1'b1;
  end

  // FIFO storage; contents need no reset because occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= in_data;
  end

  // FIFO pointers and occupancy; power-of-two depth makes pointer wrap free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
    end
  end

  // Frame FSM with registered byte outputs and the completed-frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shadow     <= '0;
      r_shadowFull <= 1'b0;
      r_outValid   <= 1'b0;
      r_outData    <= 8'h00;
      r_frameCount <= '0;
    end else if (w_lastXfer) begin
      r_frameCount <= r_frameCount + 16'd1;
      if (!w_fifoEmpty) begin
        r_shadow  <= r_mem[r_rdPtr];
        r_state   <= SYNC;
        r_outData <= SYNC_BYTE;
      end else begin
        r_state    <= IDLE;
        r_outValid <= 1'b0;
        r_outData  <= 8'h00;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (r_shadowFull) begin
            r_shadowFull <= 1'b0;
            r_state      <= SYNC;
            r_outValid   <= 1'b1;
            r_outData    <= SYNC_BYTE;
          end else if (!w_fifoEmpty) begin
            r_shadow     <= r_mem[r_rdPtr];
            r_shadowFull <= 1'b1;
          end
        end
        SYNC: begin
          if (w_xfer) begin
            r_state   <= HI;
            r_outData <= r_shadow[15:8];
          end
        end
        HI: begin
          if (w_xfer) begin
            r_state   <= LO;
            r_outData <= r_shadow[7:0];
          end
        end
`ifdef UART_TX_FRAMER_CHECKSUM_EN
        LO: begin
          if (w_xfer) begin
            r_state   <= CSUM;
            r_outData <= r_shadow[15:8] ^ r_shadow[7:0];
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: self-checking bench for uart_tx_framer.
// Expected frame bytes come from a hand-written vector table and are queued
// when a word is accepted. They are popped as the DUT hands bytes out.
// The bench honours UART_TX_FRAMER_CHECKSUM_EN so that it can check either frame length.
module tb_uart_tx_framer;

`ifdef UART_TX_FRAMER_CHECKSUM_EN
  localparam int FRAME_LEN = 4;
`else
  localparam int FRAME_LEN = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] inData = 16'h0000;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [7:0]  outData;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [15:0] frameCount;
  logic        busy;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [7:0]  cs;
  } vec_t;

  vec_t        vecs [8];
  logic [7:0]  sbQueue [$];
  int          checks = 0;
  int          errors = 0;
  int          byteIdx = 0;
  logic [15:0] expFrames = 16'h0000;
  logic        prevStall = 1'b0;
  logic [7:0]  prevData = 8'h00;
  logic        smpOutValid;
  logic [7:0]  smpOutData;
  logic        smpBusy;
  logic        lastIn;

  // Free-running clock
  always #5 clk = ~clk;

  uart_tx_framer dut (
    .clk(clk),
    .rst(rst),
    .in_data(inData),
    .in_valid(inValid),
    .in_ready(inReady),
    .out_data(outData),
    .out_valid(outValid),
    .out_ready(outReady),
    .frame_count(frameCount),
    .busy(busy)
  );

  // One comparison with a FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge and sample just after it.
  // Score any byte transfer and queue a frame for any accepted word.
  task automatic applyStimulus(input logic v, input vec_t vec, input logic r);
    @(negedge clk);
    inValid  = v;
    inData   = vec.data;
    outReady = r;
    #1;
    checkOutput("frameCount", {16'h0, frameCount}, {16'h0, expFrames});
    if (prevStall) begin
      checkOutput("holdValid", {31'h0, outValid}, 32'h1);
      checkOutput("holdData", {24'h0, outData}, {24'h0, prevData});
    end
    smpOutValid = outValid;
    smpOutData  = outData;
    smpBusy     = busy;
    lastIn      = inValid && inReady;
    if (outValid && outReady) begin
      if (sbQueue.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedByte actual=%h required=none", outData);
      end else begin
        checkOutput("frameByte", {24'h0, outData}, {24'h0, sbQueue.pop_front()});
        byteIdx++;
        if (byteIdx == FRAME_LEN) begin
          byteIdx = 0;
          expFrames = expFrames + 16'd1;
        end
      end
    end
    prevStall = outValid && !outReady;
    prevData  = outData;
    if (lastIn) begin
      sbQueue.push_back(8'hA5);
      sbQueue.push_back(vec.hi);
      sbQueue.push_back(vec.lo);
`ifdef UART_TX_FRAMER_CHECKSUM_EN
      sbQueue.push_back(vec.cs);
`endif
    end
    @(posedge clk);
  endtask

  // Offer a word until it is accepted, giving up after a bounded wait
  task automatic pushWord(input vec_t vec, input logic r);
    int n = 0;
    do begin
      applyStimulus(1'b1, vec, r);
      n++;
    end while (!lastIn && n < 50);
    if (!lastIn) begin
      checks++;
      errors++;
      $display("[TB] FAIL pushTimeout actual=notAccepted required=accepted data=%h", vec.data);
    end
  endtask

  // Run with out_ready high until every queued byte is out, then confirm idle
  task automatic drain(output int cycles);
    cycles = 0;
    while (sbQueue.size() != 0 && cycles < 200) begin
      applyStimulus(1'b0, vecs[0], 1'b1);
      cycles++;
    end
    if (cycles >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainTimeout actual=%0d left required=0 left", sbQueue.size());
    end
    applyStimulus(1'b0, vecs[0], 1'b1);
    applyStimulus(1'b0, vecs[0], 1'b1);
    checkOutput("idleValid", {31'h0, smpOutValid}, 32'h0);
    checkOutput("idleBusy", {31'h0, smpBusy}, 32'h0);
  endtask

  // Assert reset between edges and check the outputs clear without a clock
  task automatic assertReset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    inValid = 1'b0;
    outReady = 1'b0;
    #1;
    checkOutput("rstOutValid", {31'h0, outValid}, 32'h0);
    checkOutput("rstOutData", {24'h0, outData}, 32'h0);
    checkOutput("rstInReady", {31'h0, inReady}, 32'h0);
    checkOutput("rstBusy", {31'h0, busy}, 32'h0);
    checkOutput("rstFrameCount", {16'h0, frameCount}, 32'h0);
    sbQueue.delete();
    byteIdx = 0;
    expFrames = 16'h0000;
    prevStall = 1'b0;
  endtask

  // Release reset and expect in_ready on the first following edge
  task automatic releaseReset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("inReadyBeforeEdge", {31'h0, inReady}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("inReadyAfterEdge", {31'h0, inReady}, 32'h1);
  endtask

  // Watchdog so a stuck DUT still ends the run
  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    int cycles;
    int idx;
    int n;
    vecs[0] = '{16'h1234, 8'h12, 8'h34, 8'h26};
    vecs[1] = '{16'hBEEF, 8'hBE, 8'hEF, 8'h51};
    vecs[2] = '{16'h00FF, 8'h00, 8'hFF, 8'hFF};
    vecs[3] = '{16'hA55A, 8'hA5, 8'h5A, 8'hFF};
    vecs[4] = '{16'h0000, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{16'hFFFF, 8'hFF, 8'hFF, 8'h00};
    vecs[6] = '{16'h8001, 8'h80, 8'h01, 8'h81};
    vecs[7] = '{16'h5AC3, 8'h5A, 8'hC3, 8'h99};

    assertReset();
    releaseReset();

    // Latency from acceptance to the sync byte, then a stall in the high byte
    applyStimulus(1'b1, vecs[1], 1'b0);
    checkOutput("latencyAccept", {31'h0, lastIn}, 32'h1);
    applyStimulus(1'b0, vecs[1], 1'b0);
    checkOutput("latencyEdgeN", {31'h0, smpOutValid}, 32'h0);
    checkOutput("busyQueued", {31'h0, smpBusy}, 32'h1);
    applyStimulus(1'b0, vecs[1], 1'b0);
    checkOutput("latencyEdgeN1", {31'h0, smpOutValid}, 32'h0);
    applyStimulus(1'b0, vecs[1], 1'b0);
    checkOutput("latencyEdgeN2", {31'h0, smpOutValid}, 32'h1);
    checkOutput("latencySync", {24'h0, smpOutData}, 32'hA5);
    applyStimulus(1'b0, vecs[1], 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, vecs[1], 1'b0);
    checkOutput("stallHiValid", {31'h0, smpOutValid}, 32'h1);
    checkOutput("stallHiData", {24'h0, smpOutData}, 32'hBE);
    drain(cycles);

    // Table vectors pushed back to back; the drain must run one byte per cycle
    for (int i = 0; i < 8; i++) pushWord(vecs[i], 1'b1);
    n = sbQueue.size();
    drain(cycles);
    checkOutput("throughput", cycles, n);

    // Fill shadow and FIFO with the output blocked, then release in order
    assertReset();
    releaseReset();
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[idx], 1'b0);
      if (lastIn) idx++;
    end
    checkOutput("acceptedWhenBlocked", idx, 5);
    @(negedge clk);
    #1;
    checkOutput("inReadyFull", {31'h0, inReady}, 32'h0);
    drain(cycles);
    checkOutput("framesAfterBlock", {16'h0, frameCount}, 32'h5);

    // Reset in the middle of the low byte discards the frame
    pushWord(vecs[0], 1'b0);
    n = 0;
    do begin
      applyStimulus(1'b0, vecs[0], 1'b0);
      n++;
    end while (!smpOutValid && n < 10);
    applyStimulus(1'b0, vecs[0], 1'b1);
    applyStimulus(1'b0, vecs[0], 1'b1);
    applyStimulus(1'b0, vecs[0], 1'b0);
    checkOutput("inLoData", {24'h0, smpOutData}, 32'h34);
    assertReset();
    releaseReset();
    pushWord(vecs[2], 1'b1);
    drain(cycles);
    checkOutput("framesAfterMidReset", {16'h0, frameCount}, 32'h1);

    // Jump the counter to its top value rather than sending 65535 frames
    @(negedge clk);
    force dut.r_frameCount = 16'hFFFF;
    #1;
    release dut.r_frameCount;
    #1;
    checkOutput("counterPreload", {16'h0, frameCount}, 32'hFFFF);
    expFrames = 16'hFFFF;
    pushWord(vecs[3], 1'b1);
    drain(cycles);
    checkOutput("frameWrap", {16'h0, frameCount}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
